// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// mem_loader_pkg : shared header fields, op encodings and FSM states
// Revision: 1.0
// ============================================================================
package mem_loader_pkg;

   localparam logic [1:0] OP_WR_IMEM = 2'b00;
   localparam logic [1:0] OP_WR_DMEM = 2'b01;
   localparam logic [1:0] OP_RD_DMEM = 2'b10;
   localparam logic [1:0] OP_RUN     = 2'b11;

   localparam int HDR_OP_LSB   = 30;
   localparam int HDR_CNT_LSB  = 16;
   localparam int HDR_BASE_LSB = 0;
   localparam int HDR_BASE_W   = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      RD_RESP = 3'd4,
      RUN     = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_loader_addr_gen.sv
`default_nettype none
// ============================================================================
// mem_loader_addr_gen : word-aligned +4 address counter (16-bit wrap) and
//                       remaining-count down-counter with last flag
// Revision: 1.0
// ============================================================================
module mem_loader_addr_gen
   import mem_loader_pkg::*;
#(
   parameter int CNT_W = 14
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  load,
   input  logic [HDR_BASE_W-1:0] base,
   input  logic [CNT_W-1:0]      count,
   input  logic                  step,
   output logic [31:0]           addr,
   output logic                  last
);

   logic [HDR_BASE_W-1:0] r_addr;
   logic [CNT_W-1:0]      r_rem;
   logic                  w_unused_base;

   assign w_unused_base = ^base[1:0];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_addr <= '0;
         r_rem  <= '0;
      end else if (load) begin
         r_addr <= {base[HDR_BASE_W-1:2], 2'b00};
         r_rem  <= count;
      end else if (step) begin
         r_addr <= r_addr + HDR_BASE_W'(4);
         r_rem  <= r_rem - CNT_W'(1);
      end
   end

   assign addr = {{(32-HDR_BASE_W){1'b0}}, r_addr};
   assign last = (r_rem == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// mem_loader : host command-stream loader for cpu IMEM/DMEM and run control
//              optional trailing-checksum check under LOADER_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 14
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        cpu_enable,
   output logic        busy,
   output logic [31:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   input  logic [31:0] rdata_ext,
   output logic [31:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [31:0] wdata_ext_2,
   input  logic [31:0] rdata_ext_2
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic        err
`endif
);

   localparam int WAIT_W = $clog2(RD_LAT + 2);

   state_t            r_state, w_state_nxt;
   logic              w_cmd_hs, w_resp_hs;
   logic              w_gen_load, w_gen_step, w_gen_last, w_wr_strobe;
   logic [31:0]       w_gen_addr;
   logic [1:0]        w_op;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_cnt_nz, w_rd_done, w_in_trailer;
   logic              r_is_dmem;
   logic [WAIT_W-1:0] r_wait;
   logic              w_unused;

   assign w_cmd_hs  = cmd_valid && cmd_ready;
   assign w_resp_hs = resp_valid && resp_ready;
   assign w_op      = cmd_data[HDR_OP_LSB +: 2];
   assign w_cnt     = cmd_data[HDR_CNT_LSB +: CNT_W];
   assign w_cnt_nz  = (w_cnt != '0);
   assign w_rd_done = (r_wait == WAIT_W'(RD_LAT));
   assign ren_ext   = 1'b0;
   assign w_unused  = ^rdata_ext;

   mem_loader_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (w_gen_load),
      .base   (cmd_data[HDR_BASE_LSB +: HDR_BASE_W]),
      .count  (w_cnt),
      .step   (w_gen_step),
      .addr   (w_gen_addr),
      .last   (w_gen_last)
   );

`ifdef LOADER_CHECKSUM_EN
   localparam bit CKSUM = 1'b1;
   logic        r_trailer;
   logic [31:0] r_sum;

   assign w_in_trailer = r_trailer;

   // Trailer word closes the burst; it is compared, never written.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_sum     <= '0;
         r_trailer <= 1'b0;
         err       <= 1'b0;
      end else if (w_gen_load) begin
         r_sum     <= '0;
         r_trailer <= 1'b0;
      end else if (w_wr_strobe) begin
         r_sum <= r_sum + cmd_data;
         if (w_gen_last) r_trailer <= 1'b1;
      end else if (r_state == WR && w_cmd_hs && r_trailer) begin
         if (cmd_data != r_sum) err <= 1'b1;
         r_trailer <= 1'b0;
      end
   end
`else
   localparam bit CKSUM = 1'b0;
   assign w_in_trailer = 1'b0;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gen_load  = 1'b0;
      w_gen_step  = 1'b0;
      w_wr_strobe = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cmd_hs) begin
               w_gen_load = 1'b1;
               case (w_op)
                  OP_WR_IMEM, OP_WR_DMEM: if (w_cnt_nz) w_state_nxt = WR;
                  OP_RD_DMEM:             if (w_cnt_nz) w_state_nxt = RD_REQ;
                  default:                w_state_nxt = RUN;
               endcase
            end
         end
         WR: begin
            if (w_cmd_hs) begin
               if (w_in_trailer) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_wr_strobe = 1'b1;
                  w_gen_step  = 1'b1;
                  if (w_gen_last && !CKSUM) w_state_nxt = IDLE;
               end
            end
         end
         RD_REQ:  w_state_nxt = RD_WAIT;
         RD_WAIT: if (w_rd_done) w_state_nxt = RD_RESP;
         RD_RESP: begin
            if (w_resp_hs) begin
               if (w_gen_last) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_gen_step  = 1'b1;
                  w_state_nxt = RD_REQ;
               end
            end
         end
         RUN:     if (w_cmd_hs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // All host- and memory-facing outputs are registered from the next state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         cpu_enable  <= 1'b0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         addr_ext    <= '0;
         wen_ext     <= 1'b0;
         wdata_ext   <= '0;
         addr_ext_2  <= '0;
         wen_ext_2   <= 1'b0;
         ren_ext_2   <= 1'b0;
         wdata_ext_2 <= '0;
         r_is_dmem   <= 1'b0;
         r_wait      <= '0;
      end else begin
         cmd_ready  <= (w_state_nxt == IDLE) || (w_state_nxt == WR) || (w_state_nxt == RUN);
         busy       <= (w_state_nxt != IDLE);
         cpu_enable <= (w_state_nxt == RUN);
         wen_ext    <= w_wr_strobe && !r_is_dmem;
         wen_ext_2  <= w_wr_strobe && r_is_dmem;
         ren_ext_2  <= (r_state == RD_REQ);
         if (w_gen_load) r_is_dmem <= (w_op == OP_WR_DMEM);
         if (w_wr_strobe && !r_is_dmem) begin
            addr_ext  <= w_gen_addr;
            wdata_ext <= cmd_data;
         end
         if (w_wr_strobe && r_is_dmem) begin
            addr_ext_2  <= w_gen_addr;
            wdata_ext_2 <= cmd_data;
         end
         if (r_state == RD_REQ) addr_ext_2 <= w_gen_addr;
         if (r_state == RD_REQ)       r_wait <= '0;
         else if (r_state == RD_WAIT) r_wait <= r_wait + WAIT_W'(1);
         if (r_state == RD_WAIT && w_rd_done) begin
            resp_data  <= rdata_ext_2;
            resp_valid <= 1'b1;
         end else if (w_resp_hs) begin
            resp_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// tb_mem_loader : directed self-checking bench for mem_loader
// Revision: 1.0
// ============================================================================
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_data = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        cpu_enable, busy;
   logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0] rdata_ext = '0;
   logic [31:0] rdata_ext_2 = '0;
`ifdef LOADER_CHECKSUM_EN
   logic        err;
`endif

   mem_loader #(.RD_LAT(1), .CNT_W(14)) dut (
      .clk(clk), .arst_n(arst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .cpu_enable(cpu_enable), .busy(busy),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
`ifdef LOADER_CHECKSUM_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Synchronous-read DMEM model with one cycle of read latency.
   logic [31:0] dmem [0:16383];
   always @(posedge clk) begin
      if (wen_ext_2) dmem[addr_ext_2[15:2]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[15:2]];
   end

   int          cyc = 0;
   int          ren_cnt = 0;
   int          viol = 0;
   int          ren_imem_cnt = 0;
   logic [31:0] imem_addr_q[$];
   logic [31:0] imem_data_q[$];
   int          imem_cyc_q[$];
   logic [31:0] dmem_addr_q[$];
   logic [31:0] dmem_data_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wen_ext) begin
         imem_addr_q.push_back(addr_ext);
         imem_data_q.push_back(wdata_ext);
         imem_cyc_q.push_back(cyc);
      end
      if (wen_ext_2) begin
         dmem_addr_q.push_back(addr_ext_2);
         dmem_data_q.push_back(wdata_ext_2);
      end
      if (ren_ext_2) ren_cnt++;
      if (ren_ext) ren_imem_cnt++;
      if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext)) viol++;
   end

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input logic [31:0] w, output int waits);
      waits = 0;
      cmd_valid = 1'b1;
      cmd_data  = w;
      while (!cmd_ready && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) check("send_ready_timeout", {31'b0, cmd_ready}, 32'd1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_resp();
      int k = 0;
      while (!resp_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("resp_valid_arrives", {31'b0, resp_valid}, 32'd1);
   endtask

   function automatic int dmem_writes_at(input logic [31:0] a);
      int n = 0;
      foreach (dmem_addr_q[i]) if (dmem_addr_q[i] == a) n++;
      return n;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n0, r0;
      logic [31:0] exp_w [3];
      exp_w[0] = 32'hAAAA0001;
      exp_w[1] = 32'hAAAA0002;
      exp_w[2] = 32'hAAAA0003;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_cpu_enable", {31'b0, cpu_enable}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_wen", {30'b0, wen_ext, wen_ext_2}, 32'd0);
      check("rst_addr_ext", addr_ext, 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check("rst_err", {31'b0, err}, 32'd0);
`endif
      arst_n = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // IMEM burst of 3, back to back
      send(32'h0003_0010, w);
      for (int i = 0; i < 3; i++) send(exp_w[i], w);
      idle(3);
      check("imem_n_writes", imem_addr_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("imem_addr%0d", i), imem_addr_q[i], 32'h10 + 32'(4 * i));
         check($sformatf("imem_data%0d", i), imem_data_q[i], exp_w[i]);
      end
      check("imem_consec01", imem_cyc_q[1] - imem_cyc_q[0], 32'd1);
      check("imem_consec12", imem_cyc_q[2] - imem_cyc_q[1], 32'd1);
      check("imem_no_dmem_wr", dmem_addr_q.size(), 32'd0);
      check("imem_done_busy", {31'b0, busy}, 32'd0);

      // DMEM write then read back with a stalled host
      send(32'h4002_0100, w);
      send(32'd5, w);
      send(32'd7, w);
      idle(1);
      check("dmem_n_writes", dmem_addr_q.size(), 32'd2);
      check("dmem_addr1", dmem_addr_q[1], 32'h104);
      r0 = ren_cnt;
      send(32'h8002_0100, w);
      cmd_valid = 1'b0;
      check("rd_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
      wait_resp();
      check("rd0_data", resp_data, 32'd5);
      n0 = ren_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rd0_hold%0d", i), resp_data, 32'd5);
      end
      check("rd0_hold_valid", {31'b0, resp_valid}, 32'd1);
      check("rd0_no_reissue", ren_cnt - n0, 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      wait_resp();
      check("rd1_data", resp_data, 32'd7);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rd_done_valid", {31'b0, resp_valid}, 32'd0);
      check("rd_done_busy", {31'b0, busy}, 32'd0);
      check("rd_ren_pulses", ren_cnt - r0, 32'd2);

      // Zero-count header is a no-op and the next header is taken at once
      n0 = imem_addr_q.size();
      send(32'h0000_0040, w);
      check("zero_busy", {31'b0, busy}, 32'd0);
      check("zero_no_wen", imem_addr_q.size() - n0, 32'd0);
      send(32'h0001_0080, w);
      check("zero_next_immediate", w, 32'd0);
      send(32'h1234_5678, w);
      idle(2);
      check("after_zero_addr", imem_addr_q[imem_addr_q.size()-1], 32'h80);
      check("after_zero_data", imem_data_q[imem_data_q.size()-1], 32'h1234_5678);

      // Run / stop
      send(32'hC000_0000, w);
      cmd_valid = 1'b0;
      check("run_enable_rise", {31'b0, cpu_enable}, 32'd1);
      check("run_busy", {31'b0, busy}, 32'd1);
      repeat (20) @(negedge clk);
      check("run_enable_held", {31'b0, cpu_enable}, 32'd1);
      send(32'hDEAD_BEEF, w);
      cmd_valid = 1'b0;
      check("run_enable_fall", {31'b0, cpu_enable}, 32'd0);
      check("run_stop_busy", {31'b0, busy}, 32'd0);

      // Reset in the middle of a burst
      n0 = imem_addr_q.size();
      send(32'h0003_0200, w);
      send(32'hBBBB_0001, w);
      cmd_valid = 1'b0;
      check("mid_wen_before", {31'b0, wen_ext}, 32'd1);
      #2 arst_n = 1'b0;
      #1;
      check("mid_rst_wen", {31'b0, wen_ext}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("mid_rst_addr", addr_ext, 32'd0);
      check("mid_rst_wdata", wdata_ext, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      check("mid_post_ready", {31'b0, cmd_ready}, 32'd1);
      check("mid_n_imem", imem_addr_q.size() - n0, 32'd1);
      send(32'h4001_0300, w);
      send(32'h0000_0055, w);
      idle(2);
      check("mid_next_addr", dmem_addr_q[dmem_addr_q.size()-1], 32'h300);
      check("mid_next_data", dmem_data_q[dmem_data_q.size()-1], 32'h55);

`ifdef LOADER_CHECKSUM_EN
      n0 = dmem_addr_q.size();
      send(32'h4002_0400, w); send(32'd1, w); send(32'd2, w); send(32'd3, w);
      idle(2);
      check("ck_good_err", {31'b0, err}, 32'd0);
      check("ck_good_writes", dmem_addr_q.size() - n0, 32'd2);
      check("ck_good_busy", {31'b0, busy}, 32'd0);
      send(32'h4002_0500, w); send(32'd1, w); send(32'd2, w); send(32'd4, w);
      idle(2);
      check("ck_bad_err", {31'b0, err}, 32'd1);
      send(32'h4001_0600, w); send(32'd9, w); send(32'd9, w);
      idle(2);
      check("ck_sticky_err", {31'b0, err}, 32'd1);
      check("ck_no_trailer_408", dmem_writes_at(32'h408), 32'd0);
      check("ck_no_trailer_508", dmem_writes_at(32'h508), 32'd0);
      check("ck_no_trailer_604", dmem_writes_at(32'h604), 32'd0);
      check("ck_total_writes", dmem_addr_q.size() - n0, 32'd5);
`endif

      check("no_strobe_while_enabled", viol, 32'd0);
      check("imem_ren_never", ren_imem_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Host-side load/run controller. It drives the external instruction-memory and data-memory access ports of the pipelined cpu, and it owns the cpu `enable` input.
- It accepts a 32-bit valid/ready command stream that carries headers and payload words. From that stream it writes IMEM/DMEM, reads DMEM back onto a valid/ready response stream, and starts or stops execution.
- It sits between the testbench/host link and the cpu top.

Parameters:
- RD_LAT, 1, cycles from ren_ext_2 asserted to rdata_ext_2 valid (sram synchronous read).
- CNT_W, 14, width of the header word-count field.

Ports:
- clk  in  1  clock; all logic rising-edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  loader accepts cmd_data this cycle.
- cmd_data  in  32  header or payload word.
- resp_valid  out  1  readback word valid.
- resp_ready  in  1  host accepts resp_data.
- resp_data  out  32  DMEM readback word.
- cpu_enable  out  1  drives cpu `enable`.
- busy  out  1  state != IDLE.
- addr_ext  out  32  IMEM byte address.
- wen_ext  out  1  IMEM write strobe.
- ren_ext  out  1  IMEM read strobe, tied 0.
- wdata_ext  out  32  IMEM write data.
- rdata_ext  in  32  unused.
- addr_ext_2  out  32  DMEM byte address.
- wen_ext_2  out  1  DMEM write strobe.
- ren_ext_2  out  1  DMEM read strobe.
- wdata_ext_2  out  32  DMEM write data.
- rdata_ext_2  in  32  DMEM read data.
- err  out  1  sticky checksum error; present only with LOADER_CHECKSUM_EN.

Behaviour:
- One clock, clk. Reset arst_n is asynchronous, active-low.
- Header format: [31:30] op, [29:16] count, [15:0] base byte address.
  - op 00: write IMEM.
  - op 01: write DMEM.
  - op 10: read DMEM.
  - op 11: run.
- Addressing: the address of word i is base + 4*i, a 32-bit byte address. base[1:0] is ignored and forced to 0. Addresses wrap modulo 2^16 within base.
- Reset values: all outputs 0, state IDLE, counters 0, err 0.
- IDLE:
  - cmd_ready = 1.
  - On header handshake: latch op, count and base.
  - op 00/01 with count > 0 -> WR.
  - op 10 with count > 0 -> RD_REQ.
  - count = 0 for op 00/01/10 -> stay IDLE (no-op).
  - op 11 -> RUN; cpu_enable rises the next cycle.
- WR:
  - cmd_ready = 1, one word per cycle.
  - Each handshake registers a single-cycle strobe on the cycle after: wen_ext (op 00) or wen_ext_2 (op 01), together with the address and wdata.
  - The address advances by 4 and the remaining count decrements.
  - On the last word -> IDLE.
  - A cmd_valid bubble stalls with no strobe.
- RD_REQ: assert ren_ext_2 for 1 cycle with the address -> RD_WAIT.
- RD_WAIT: wait RD_LAT cycles, capture rdata_ext_2 into resp_data, resp_valid = 1 -> RD_RESP.
- RD_RESP:
  - Hold resp_valid and resp_data stable until resp_ready.
  - On handshake: if the remaining count is > 1, advance the address and go to RD_REQ; otherwise go to IDLE.
  - There is only one read outstanding at a time.
  - cmd_ready = 0 in RD_REQ, RD_WAIT and RD_RESP.
- RUN:
  - cpu_enable = 1, cmd_ready = 1.
  - Any accepted word stops execution: it is consumed and discarded, cpu_enable falls the next cycle, and the state returns to IDLE.
- Invariant: no ext strobe (wen/ren on either memory) is ever asserted while cpu_enable = 1.
- Ordering: the final WR strobe precedes any cpu_enable rise by at least 1 cycle.
- A reset mid-burst aborts immediately: strobes drop asynchronously, and the remaining payload is discarded by the host protocol.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Each write burst carries one extra trailing word, which is the 32-bit modulo-2^32 sum of its payload words.
  - WR accepts count+1 words; the trailing word is not written to memory.
  - On mismatch, err is set and stays set until reset.
  - The err port exists only when the macro is defined.
- When undefined:
  - There is no trailing word, no accumulator and no err port.

Decomposition:
- Shared package:
  - op encodings: OP_WR_IMEM, OP_WR_DMEM, OP_RD_DMEM, OP_RUN.
  - header field bit positions.
  - state enum IDLE, WR, RD_REQ, RD_WAIT, RD_RESP, RUN.
- Sub-module: mem_loader_addr_gen, holding the base latch, the +4 address counter and the remaining-count down-counter with a last flag, shared by WR and RD.
- The FSM and the output registers stay in the top module.

Test Plan:
- Write IMEM: header 0x0003_0010 then 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 back-to-back -> wen_ext pulses on 3 consecutive cycles at addresses 0x10, 0x14, 0x18 with matching data; wen_ext_2 stays 0.
- DMEM write then read:
  - write header 0x4002_0100 with words 5 and 7, then read header 0x8002_0100 -> resp words 5, 7 in order.
  - With resp_ready held low for 4 cycles, resp_data stays stable and ren_ext_2 is not re-asserted.
- Run/stop: header 0xC000_0000 -> cpu_enable = 1 from the next cycle; any word 20 cycles later -> cpu_enable = 0 the following cycle; no ext strobes while enabled.
- Zero count: header 0x0000_0040 -> no wen_ext, busy stays 0, next header is accepted immediately.
- Reset mid-burst: arst_n low after 1 of 3 words -> all outputs 0 asynchronously, state IDLE; the next header is processed normally.
- LOADER_CHECKSUM_EN: DMEM burst of 1, 2 with trailer 3 -> err = 0; with trailer 4 -> err = 1 and sticky; trailer address is never written.
